prefetch_buffer: RTL and testbench

- Instruction prefetch stage directly upstream of the fetch stage of the RV32 pipeline; replaces the bare PC-increment path.
- Issues sequential 32-bit word reads to instruction memory, buffers in-order responses in a DEPTH-entry FIFO, and presents {instruction, PC} pairs to fetch with a valid/ready handshake.
- Accepts a redirect (branch/jump/trap) that flushes the buffer, discards in-flight responses and restarts at a new PC.

---
 rtl/prefetch_buffer.sv | 110 +++++++++++
 tb/tb_prefetch_buffer.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/prefetch_buffer.sv
// Sequential instruction prefetcher: credit-limited word reads into a DEPTH-entry FIFO, with redirect flush.
// Optional macro PFB_BYPASS_EN presents a response straight to fetch when the FIFO is empty.
module prefetch_buffer #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_gnt_i,
    input  logic        imem_rvalid_i,
    input  logic [31:0] imem_rdata_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic        instr_valid_o,
    output logic [31:0] instr_o,
    output logic [31:0] instr_pc_o,
    input  logic        instr_ready_i
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [31:0]   mem_instr [DEPTH];
    logic [31:0]   mem_pc    [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count, outstanding, discard;
    logic [31:0]   req_addr, rsp_pc;
    logic [CW:0]   credits;
    logic [31:0]   redirect_addr;
    logic          grant, rsp_keep, bypass, push, pop, head_valid;

    // Credits cover both buffered and in-flight words, so a response always has a free slot.
    assign credits       = {1'b0, count} + {1'b0, outstanding};
    assign imem_req_o    = !rst_i && !redirect_i && (credits < (CW+1)'(DEPTH));
    assign imem_addr_o   = req_addr;
    assign grant         = imem_req_o && imem_gnt_i;
    assign redirect_addr = {redirect_pc_i[31:2], 2'b00};

    assign head_valid = (count != '0);
    assign rsp_keep   = imem_rvalid_i && (discard == '0) && !redirect_i;

`ifdef PFB_BYPASS_EN
    assign bypass = rsp_keep && !head_valid;
`else
    assign bypass = 1'b0;
`endif

    assign instr_valid_o = (head_valid || bypass) && !redirect_i;
    assign instr_o       = bypass ? imem_rdata_i : mem_instr[rd_ptr];
    assign instr_pc_o    = bypass ? rsp_pc       : mem_pc[rd_ptr];
    assign pop           = head_valid && !redirect_i && instr_ready_i;
    assign push          = rsp_keep && !(bypass && instr_ready_i);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_instr[i] <= '0;
                mem_pc[i]    <= '0;
            end
        end else if (push) begin
            mem_instr[wr_ptr] <= imem_rdata_i;
            mem_pc[wr_ptr]    <= rsp_pc;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            outstanding <= '0;
            discard     <= '0;
            req_addr    <= RESET_PC;
            rsp_pc      <= RESET_PC;
        end else begin
            case ({grant, imem_rvalid_i})
                2'b10:   outstanding <= outstanding + CW'(1);
                2'b01:   outstanding <= outstanding - CW'(1);
                default: outstanding <= outstanding;
            endcase

            if (redirect_i) begin
                // A response landing in the redirect cycle is already stale; count it as dropped.
                wr_ptr   <= '0;
                rd_ptr   <= '0;
                count    <= '0;
                discard  <= outstanding - CW'(imem_rvalid_i);
                req_addr <= redirect_addr;
                rsp_pc   <= redirect_addr;
            end else begin
                if (grant)
                    req_addr <= req_addr + 32'd4;
                if (imem_rvalid_i && (discard != '0))
                    discard <= discard - CW'(1);
                if (rsp_keep)
                    rsp_pc <= rsp_pc + 32'd4;
                if (push)
                    wr_ptr <= wr_ptr + AW'(1);
                if (pop)
                    rd_ptr <= rd_ptr + AW'(1);
                case ({push, pop})
                    2'b10:   count <= count + CW'(1);
                    2'b01:   count <= count - CW'(1);
                    default: count <= count;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_prefetch_buffer.sv
// Directed bench for prefetch_buffer: per-cycle vector table for start-up and redirect timing,
// then hand-written sequences for back-pressure, discard, address wrap and async reset.
module tb_prefetch_buffer;
    localparam logic [31:0] RST_PC = 32'h0000_0000;
`ifdef PFB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_gnt_i;
    logic        imem_rvalid_i;
    logic [31:0] imem_rdata_i;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic        instr_valid_o;
    logic [31:0] instr_o;
    logic [31:0] instr_pc_o;
    logic        instr_ready_i;

    prefetch_buffer #(.DEPTH(4), .RESET_PC(RST_PC)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o), .imem_gnt_i(imem_gnt_i),
        .imem_rvalid_i(imem_rvalid_i), .imem_rdata_i(imem_rdata_i),
        .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i),
        .instr_valid_o(instr_valid_o), .instr_o(instr_o), .instr_pc_o(instr_pc_o),
        .instr_ready_i(instr_ready_i)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        bit          redir;
        logic [31:0] rpc;
        bit          ready;
        bit          gnt;
        bit          e_req;
        logic [31:0] e_addr;
        bit          e_valid;
        logic [31:0] e_pc;
    } vec_t;

    vec_t        tbl [10];
    int          n_tests = 0;
    int          n_fail  = 0;
    int          ngrant  = 0;
    bit          rsp_en  = 1'b1;
    logic [31:0] memq[$];
    logic [31:0] pop_pc[$];
    logic [31:0] pop_data[$];

    function automatic logic [31:0] mf(input logic [31:0] a);
        return a ^ 32'h5A5A_0F0F;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One clock: log grants/pops just before the edge, then advance the 1-cycle-latency memory.
    task automatic cycle();
        bit          g;
        bit          r_acc;
        logic [31:0] ga;
        #1;
        g     = imem_req_o && imem_gnt_i;
        ga    = imem_addr_o;
        r_acc = imem_rvalid_i;
        if (instr_valid_o && instr_ready_i) begin
            pop_pc.push_back(instr_pc_o);
            pop_data.push_back(instr_o);
        end
        if (g) ngrant++;
        @(posedge clk_i);
        #1;
        if (r_acc && memq.size() > 0) void'(memq.pop_front());
        if (g) memq.push_back(ga);
        if (rsp_en && memq.size() > 0) begin
            imem_rvalid_i = 1'b1;
            imem_rdata_i  = mf(memq[0]);
        end else begin
            imem_rvalid_i = 1'b0;
            imem_rdata_i  = '0;
        end
    endtask

    task automatic clear_log();
        pop_pc.delete();
        pop_data.delete();
    endtask

    task automatic collect(input int n, input int budget);
        for (int i = 0; i < budget && pop_pc.size() < n; i++) cycle();
        chk("collect_count", pop_pc.size(), n);
    endtask

    task automatic check_seq(input logic [31:0] base, input int n);
        logic [31:0] pc;
        for (int i = 0; i < n && i < pop_pc.size(); i++) begin
            pc = base + 32'(4 * i);
            chk($sformatf("seq_pc[%0d]", i), pop_pc[i], pc);
            chk($sformatf("seq_data[%0d]", i), pop_data[i], mf(pc));
        end
    endtask

    task automatic set_row(input int i, input bit redir, input logic [31:0] rpc,
                           input bit e_req, input logic [31:0] e_addr,
                           input bit e_valid, input logic [31:0] e_pc);
        tbl[i] = '{redir: redir, rpc: rpc, ready: 1'b1, gnt: 1'b1,
                   e_req: e_req, e_addr: e_addr, e_valid: e_valid, e_pc: e_pc};
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Start-up stream then a redirect that coincides with a response and a pop.
        set_row(0, 0, 0, 1, 32'h0000, 0,   32'h0);
        set_row(1, 0, 0, 1, 32'h0004, BYP, 32'h0);
        set_row(2, 0, 0, 1, 32'h0008, 1,   BYP ? 32'h4 : 32'h0);
        set_row(3, 0, 0, 1, 32'h000C, 1,   BYP ? 32'h8 : 32'h4);
        set_row(4, 0, 0, 1, 32'h0010, 1,   BYP ? 32'hC : 32'h8);
        set_row(5, 1, 32'h1003, 0, 32'h0014, 0, 32'h0);
        set_row(6, 0, 0, 1, 32'h1000, 0,   32'h0);
        set_row(7, 0, 0, 1, 32'h1004, BYP, 32'h1000);
        set_row(8, 0, 0, 1, 32'h1008, 1,   BYP ? 32'h1004 : 32'h1000);
        set_row(9, 0, 0, 1, 32'h100C, 1,   BYP ? 32'h1008 : 32'h1004);

        rst_i = 1'b1; imem_gnt_i = 1'b0; imem_rvalid_i = 1'b0; imem_rdata_i = '0;
        redirect_i = 1'b0; redirect_pc_i = '0; instr_ready_i = 1'b0;
        repeat (2) @(posedge clk_i);
        #2;
        chk("rst_req",   imem_req_o,    1'b0);
        chk("rst_addr",  imem_addr_o,   RST_PC);
        chk("rst_valid", instr_valid_o, 1'b0);
        chk("rst_instr", instr_o,       32'h0);
        chk("rst_pc",    instr_pc_o,    32'h0);
        rst_i = 1'b0;

        for (int i = 0; i < 10; i++) begin
            redirect_i    = tbl[i].redir;
            redirect_pc_i = tbl[i].rpc;
            instr_ready_i = tbl[i].ready;
            imem_gnt_i    = tbl[i].gnt;
            #1;
            chk($sformatf("row%0d_req", i),   imem_req_o,    tbl[i].e_req);
            chk($sformatf("row%0d_addr", i),  imem_addr_o,   tbl[i].e_addr);
            chk($sformatf("row%0d_valid", i), instr_valid_o, tbl[i].e_valid);
            if (tbl[i].e_valid) begin
                chk($sformatf("row%0d_pc", i),    instr_pc_o, tbl[i].e_pc);
                chk($sformatf("row%0d_instr", i), instr_o,    mf(tbl[i].e_pc));
            end
            cycle();
        end
        redirect_i = 1'b0;

        // Back-pressure: only DEPTH new grants, then in-order release.
        redirect_i = 1'b1; redirect_pc_i = 32'h0000_0200; instr_ready_i = 1'b0;
        cycle();
        redirect_i = 1'b0; ngrant = 0; clear_log();
        repeat (12) cycle();
        #1;
        chk("bp_grants", ngrant,        4);
        chk("bp_req",    imem_req_o,    1'b0);
        chk("bp_valid",  instr_valid_o, 1'b1);
        chk("bp_pc",     instr_pc_o,    32'h0000_0200);
        instr_ready_i = 1'b1;
        collect(8, 40);
        check_seq(32'h0000_0200, 8);

        // Three reads in flight when redirected: all three must be dropped.
        imem_gnt_i = 1'b0;
        repeat (6) cycle();
        rsp_en = 1'b0; imem_gnt_i = 1'b1;
        repeat (3) cycle();
        imem_gnt_i = 1'b0;
        #1;
        chk("inflight_queue", memq.size(), 3);
        redirect_i = 1'b1; redirect_pc_i = 32'h0000_1003; rsp_en = 1'b1; imem_gnt_i = 1'b1;
        cycle();
        redirect_i = 1'b0; clear_log();
        collect(3, 30);
        check_seq(32'h0000_1000, 3);

        // Address wrap across 2^32.
        redirect_i = 1'b1; redirect_pc_i = 32'hFFFF_FFF9;
        cycle();
        redirect_i = 1'b0; clear_log();
        collect(4, 30);
        check_seq(32'hFFFF_FFF8, 4);

        // Two entries buffered, then asynchronous reset between edges.
        redirect_i = 1'b1; redirect_pc_i = 32'h0000_0400; instr_ready_i = 1'b0;
        cycle();
        redirect_i = 1'b0;
        repeat (2) cycle();
        imem_gnt_i = 1'b0;
        repeat (4) cycle();
        #1;
        chk("pre_rst_valid", instr_valid_o, 1'b1);
        chk("pre_rst_pc",    instr_pc_o,    32'h0000_0400);
        #2;
        rst_i = 1'b1;
        #1;
        chk("arst_valid", instr_valid_o, 1'b0);
        chk("arst_addr",  imem_addr_o,   RST_PC);
        chk("arst_req",   imem_req_o,    1'b0);
        chk("arst_pc",    instr_pc_o,    32'h0);
        memq.delete(); imem_rvalid_i = 1'b0; imem_rdata_i = '0;
        @(posedge clk_i);
        #1;
        rst_i = 1'b0; imem_gnt_i = 1'b1; instr_ready_i = 1'b1; clear_log();
        cycle();
        #1;
        chk("bypass_valid", instr_valid_o, BYP);
        collect(4, 20);
        check_seq(RST_PC, 4);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
